// File: rtl/pause_arbiter.sv
// CPU/PSG freeze controller: debounced toggle button plus two level requests,
// sequencing Z80 WAIT_n and the AY clock enable around a memory cycle.
module pause_arbiter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ARM_TIMEOUT     = 255,
    parameter int RESUME_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulsador,
    input  logic       req_osd,
    input  logic       req_ext,
    input  logic       cpu_mreq_n,
    output logic       wait_n,
    output logic       enable_clkay,
    output logic       paused,
    output logic [1:0] owner,
    output logic       btn_pulse
);

    localparam logic [15:0] DB_MAX   = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  ARM_MAX  = 8'(ARM_TIMEOUT);
    localparam logic [7:0]  ARM_LAST = 8'(ARM_TIMEOUT - 1);
    localparam logic [3:0]  GAP_MAX  = 4'(RESUME_GAP);
    localparam logic [3:0]  GAP_LAST = 4'(RESUME_GAP - 1);

    typedef enum logic [1:0] {S_RUN, S_ARM, S_PAUSED, S_RESUME} state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2, db_level, btn_latch;
    logic [15:0] db_cnt;
    logic [7:0]  arm_cnt;
    logic [3:0]  gap_cnt;
    logic        db_differ, db_fire, db_rise, any_req;
    logic [1:0]  owner_req;

    assign db_differ = sync2 ^ db_level;
    assign db_fire   = db_differ && (db_cnt == DB_LAST);
    assign db_rise   = db_fire && sync2;
    assign any_req   = btn_latch | req_osd | req_ext;

    // Debounced level only moves after a full run of disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_level  <= 1'b0;
            db_cnt    <= '0;
            btn_latch <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync1     <= pulsador;
            sync2     <= sync1;
            if (!db_differ)
                db_cnt <= '0;
            else if (db_cnt != DB_MAX)
                db_cnt <= db_cnt + 16'd1;
            if (db_fire)
                db_level <= sync2;
            btn_pulse <= db_rise;
            if (db_rise)
                btn_latch <= ~btn_latch;
        end
    end

    always_comb begin
        owner_req = 2'b00;
        if (req_ext)
            owner_req = 2'b11;
        else if (req_osd)
            owner_req = 2'b10;
        else if (btn_latch)
            owner_req = 2'b01;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:    if (any_req) state_nxt = S_ARM;
            S_ARM: begin
                // Withdrawal wins over a simultaneous memory cycle.
                if (!any_req)
                    state_nxt = S_RUN;
                else if (!cpu_mreq_n || arm_cnt >= ARM_LAST)
                    state_nxt = S_PAUSED;
            end
            S_PAUSED: if (!any_req) state_nxt = S_RESUME;
            S_RESUME: begin
                if (any_req)
                    state_nxt = S_ARM;
                else if (gap_cnt >= GAP_LAST)
                    state_nxt = S_RUN;
            end
            default:  state_nxt = S_RUN;
        endcase
    end

    // Outputs are registered from the next state so they change with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            arm_cnt      <= '0;
            gap_cnt      <= '0;
            wait_n       <= 1'b1;
            enable_clkay <= 1'b1;
            paused       <= 1'b0;
            owner        <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == S_ARM && state_nxt == S_ARM)
                arm_cnt <= (arm_cnt == ARM_MAX) ? ARM_MAX : arm_cnt + 8'd1;
            else
                arm_cnt <= '0;
            if (state == S_RESUME && state_nxt == S_RESUME)
                gap_cnt <= (gap_cnt == GAP_MAX) ? GAP_MAX : gap_cnt + 4'd1;
            else
                gap_cnt <= '0;
            wait_n       <= (state_nxt != S_PAUSED);
            enable_clkay <= (state_nxt == S_RUN);
            paused       <= (state_nxt == S_PAUSED);
            case (state_nxt)
                S_RUN:            owner <= 2'b00;
                S_ARM, S_PAUSED:  owner <= owner_req;
                default:          owner <= owner;
            endcase
        end
    end

endmodule

// File: tb/tb_pause_arbiter.sv
// Directed + randomized bench for pause_arbiter, checked every cycle against a
// phase/timestamp reference model plus directed latency and ownership checks.
module tb_pause_arbiter;

    localparam int DB     = 64;
    localparam int ARM_TO = 255;
    localparam int GAP    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulsador = 1'b0;
    logic       req_osd = 1'b0;
    logic       req_ext = 1'b0;
    logic       cpu_mreq_n = 1'b1;
    logic       wait_n, enable_clkay, paused, btn_pulse;
    logic [1:0] owner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pause_arbiter #(
        .DEBOUNCE_CYCLES(DB),
        .ARM_TIMEOUT    (ARM_TO),
        .RESUME_GAP     (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulsador    (pulsador),
        .req_osd     (req_osd),
        .req_ext     (req_ext),
        .cpu_mreq_n  (cpu_mreq_n),
        .wait_n      (wait_n),
        .enable_clkay(enable_clkay),
        .paused      (paused),
        .owner       (owner),
        .btn_pulse   (btn_pulse)
    );

    // Reference model: phase 0=run 1=arm 2=paused 3=resume, with the cycle
    // number at which the current phase was entered.
    int       cyc = 0;
    int       m_ph, m_entered;
    bit       m_s1, m_s2, m_db, m_latch, m_pulse;
    int       m_run;
    bit [1:0] m_owner;

    task automatic model_reset();
        m_ph = 0; m_entered = cyc;
        m_s1 = 0; m_s2 = 0; m_db = 0; m_latch = 0; m_pulse = 0;
        m_run = 0; m_owner = 2'b00;
    endtask

    task automatic model_step();
        bit       any, flip;
        bit [1:0] want;
        int       nph, spent;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        any  = m_latch | req_osd | req_ext;
        want = req_ext ? 2'b11 : req_osd ? 2'b10 : m_latch ? 2'b01 : 2'b00;
        // button: DB consecutive disagreeing samples of the delayed input
        flip = 0;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DB) begin flip = 1; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_pulse = flip && !m_db;
        if (flip) m_db = !m_db;
        if (m_pulse) m_latch = !m_latch;
        m_s2 = m_s1;
        m_s1 = pulsador;
        // phases: spent = cycles already in this phase including this one
        spent = cyc - m_entered;
        nph = m_ph;
        case (m_ph)
            0: if (any) nph = 1;
            1: if (!any) nph = 0; else if (!cpu_mreq_n || spent >= ARM_TO) nph = 2;
            2: if (!any) nph = 3;
            default: if (any) nph = 1; else if (spent >= GAP) nph = 0;
        endcase
        if (nph != m_ph) m_entered = cyc;
        if (nph == 1 || nph == 2) m_owner = want;
        else if (nph == 0) m_owner = 2'b00;
        m_ph = nph;
    endtask

    function automatic logic [5:0] dut_vec();
        return {wait_n, enable_clkay, paused, owner, btn_pulse};
    endfunction

    function automatic logic [5:0] mdl_vec();
        return {(m_ph != 2), (m_ph == 0), (m_ph == 2), m_owner, m_pulse};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model advances with the inputs present at the edge, DUT is
    // sampled on the following falling edge.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk(tag, 32'(dut_vec()), 32'(mdl_vec()));
    endtask

    task automatic wait_pulse(input string tag, output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int i = 1; i <= DB + 10 && !got; i++) begin
            tick(tag);
            if (btn_pulse) begin got = 1; lat = i; end
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int lat, npulse, a, g;
        bit minw;
        model_reset();
        @(negedge clk);

        // reset and idle
        repeat (3) tick("reset");
        chk("reset_vals", 32'(dut_vec()), 32'b110000);
        rst = 1'b0;
        repeat (5) tick("idle");

        // bouncy button, then a stable press
        for (int i = 0; i < 6; i++) begin
            pulsador = (i % 2 == 0);
            repeat (10) tick("bounce");
        end
        pulsador = 1'b1;
        wait_pulse("press1", lat);
        chk("btn_latency", 32'(lat), 32'(DB + 2));
        repeat (5) tick("arm_btn");
        cpu_mreq_n = 1'b0;
        tick("mreq_btn");
        cpu_mreq_n = 1'b1;
        chk("btn_freeze", 32'({wait_n, owner}), 32'b001);
        npulse = 0;
        repeat (DB) begin tick("hold"); if (btn_pulse) npulse++; end
        chk("single_pulse", 32'(npulse), 32'd0);
        pulsador = 1'b0;
        repeat (DB + 4) tick("release");
        chk("release_no_effect", 32'({paused, owner}), 32'b101);

        // second press resumes with the enable gap
        pulsador = 1'b1;
        wait_pulse("press2", lat);
        tick("resume1");
        chk("resume_entry", 32'({wait_n, enable_clkay, paused}), 32'b100);
        g = 1;
        while (!enable_clkay && g < 20) begin
            tick("resume_gap");
            if (!enable_clkay) g++;
        end
        chk("resume_gap_len", 32'(g), 32'(GAP));
        pulsador = 1'b0;
        repeat (DB + 4) tick("release2");

        // forced freeze with no memory cycle
        req_ext = 1'b1;
        a = 0;
        tick("forced_arm");
        while (!paused && a < 400) begin a++; tick("forced_arm"); end
        chk("arm_timeout_len", 32'(a), 32'(ARM_TO));
        chk("forced_state", 32'({paused, owner, wait_n}), 32'b1110);
        req_ext = 1'b0;
        repeat (8) tick("forced_exit");

        // priority and handover
        req_osd = 1'b1; cpu_mreq_n = 1'b0;
        repeat (2) tick("osd_pause");
        chk("owner_osd", 32'({paused, owner}), 32'b110);
        req_ext = 1'b1;
        tick("ext_over");
        chk("owner_ext", 32'(owner), 32'd3);
        req_ext = 1'b0;
        tick("ext_drop");
        chk("owner_back_osd", 32'(owner), 32'd2);
        req_osd = 1'b0; cpu_mreq_n = 1'b1;
        tick("osd_drop");
        chk("handover_resume", 32'({wait_n, enable_clkay, paused, owner}), 32'b10010);
        repeat (5) tick("to_run");
        chk("handover_run", 32'({enable_clkay, owner}), 32'b100);

        // withdrawal in ARM
        minw = 1;
        req_osd = 1'b1;
        repeat (3) begin tick("withdraw_arm"); minw &= wait_n; end
        req_osd = 1'b0;
        tick("withdraw");
        chk("withdraw_run", 32'({wait_n, enable_clkay, minw}), 32'b111);

        // re-request during RESUME
        req_osd = 1'b1; cpu_mreq_n = 1'b0;
        repeat (2) tick("rereq_pause");
        req_osd = 1'b0; cpu_mreq_n = 1'b1;
        repeat (2) tick("rereq_resume");
        req_osd = 1'b1;
        tick("rereq_arm");
        chk("rereq_arm_state", 32'({wait_n, enable_clkay, paused, owner}), 32'b10010);
        cpu_mreq_n = 1'b0;
        tick("rereq_freeze");
        req_osd = 1'b0; cpu_mreq_n = 1'b1;
        repeat (6) tick("rereq_exit");

        // button latched across an OSD pause
        req_osd = 1'b1; cpu_mreq_n = 1'b0;
        repeat (2) tick("latch_osd");
        cpu_mreq_n = 1'b1;
        pulsador = 1'b1;
        wait_pulse("press_in_osd", lat);
        chk("owner_osd_over_btn", 32'(owner), 32'd2);
        pulsador = 1'b0;
        repeat (DB + 4) tick("latch_release");
        req_osd = 1'b0;
        repeat (10) tick("latch_hold");
        chk("latched_pause", 32'({paused, owner}), 32'b101);

        // asynchronous reset while frozen
        rst = 1'b1;
        #1;
        chk("rst_async", 32'(dut_vec()), 32'b110000);
        repeat (3) tick("in_reset");
        rst = 1'b0;
        repeat (5) tick("post_reset");
        chk("post_reset_idle", 32'({wait_n, enable_clkay, owner}), 32'b1100);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) req_osd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 23) == 0) req_ext = 1'($urandom_range(0, 1));
            cpu_mreq_n = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) pulsador = ~pulsador;
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
